// File: rtl/target_placer_if.sv
// Random-value request channel between the pinball target placer and the
// 9-bit pseudo-random generator. The placer raises rand_req; the generator
// answers with rand_in qualified by rand_valid.
interface target_placer_if;
    logic       rand_req;
    logic [8:0] rand_in;
    logic       rand_valid;

    // Consumer side: the target placer requests values
    modport master (
        output rand_req,
        input  rand_in,
        input  rand_valid
    );

    // Producer side: the random generator supplies values
    modport slave (
        input  rand_req,
        output rand_in,
        output rand_valid
    );
endinterface

// File: rtl/target_placer.sv
// Pinball bonus target placer. Draws x then y from the random source,
// rejecting out-of-range values and clamping after too many rejections,
// keeps the target visible until hit, then waits a cooldown before
// drawing a fresh position.
module target_placer #(
    parameter int X_MIN         = 10,
    parameter int X_MAX         = 380,
    parameter int Y_MIN         = 40,
    parameter int Y_MAX         = 200,
    parameter int MAX_RETRY     = 8,
    parameter int RESPAWN_DELAY = 1000
) (
    input  logic                   CLK,
    input  logic                   reset,
    target_placer_if.master        rng,
    input  logic                   hit,
    output logic [8:0]             target_x,
    output logic [8:0]             target_y,
    output logic                   target_active,
    output logic [7:0]             spawn_count
);

    localparam logic [8:0] X_MIN_C = 9'(X_MIN);
    localparam logic [8:0] X_MAX_C = 9'(X_MAX);
    localparam logic [8:0] Y_MIN_C = 9'(Y_MIN);
    localparam logic [8:0] Y_MAX_C = 9'(Y_MAX);

    // Retry counter only ever needs to reach MAX_RETRY-1
    localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST =
        (MAX_RETRY > 1) ? RETRY_W'(MAX_RETRY - 1) : RETRY_W'(0);

    // Cooldown counter holds at most RESPAWN_DELAY-1; a delay of 0 acts as 1
    localparam int CNT_W = (RESPAWN_DELAY > 2) ? $clog2(RESPAWN_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (RESPAWN_DELAY > 1) ? CNT_W'(RESPAWN_DELAY - 1) : CNT_W'(0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAW_X   = 3'd1,
        DRAW_Y   = 3'd2,
        ACTIVE   = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    state_t               state_r, next_state_s;
    logic [RETRY_W-1:0]   retry_r, retry_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic [8:0]           x_r, x_nxt_s;
    logic [8:0]           y_r, y_nxt_s;
    logic [7:0]           spawn_r, spawn_nxt_s;
    logic                 rand_req_r;
    logic                 active_r;
    logic                 xfer_s;
    logic                 last_try_s;

    // Saturate a draw into [lo, hi]; an in-range value passes unchanged,
    // so the same path serves both normal acceptance and the fallback.
    function automatic logic [8:0] clamp9(input logic [8:0] v,
                                          input logic [8:0] lo,
                                          input logic [8:0] hi);
        logic [8:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic in_range9(input logic [8:0] v,
                                       input logic [8:0] lo,
                                       input logic [8:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign xfer_s     = rand_req_r & rng.rand_valid;
    assign last_try_s = (retry_r >= RETRY_LAST);

    // Next-state and datapath update for the draw / active / cooldown cycle
    always_comb begin
        next_state_s = state_r;
        retry_nxt_s  = retry_r;
        cnt_nxt_s    = cnt_r;
        x_nxt_s      = x_r;
        y_nxt_s      = y_r;
        spawn_nxt_s  = spawn_r;
        case (state_r)
            IDLE: begin
                next_state_s = DRAW_X;
            end
            DRAW_X: begin
                if (xfer_s) begin
                    if (in_range9(rng.rand_in, X_MIN_C, X_MAX_C) || last_try_s) begin
                        x_nxt_s      = clamp9(rng.rand_in, X_MIN_C, X_MAX_C);
                        retry_nxt_s  = RETRY_W'(0);
                        next_state_s = DRAW_Y;
                    end else begin
                        retry_nxt_s  = retry_r + RETRY_W'(1);
                    end
                end else begin
                    retry_nxt_s = retry_r;
                end
            end
            DRAW_Y: begin
                if (xfer_s) begin
                    if (in_range9(rng.rand_in, Y_MIN_C, Y_MAX_C) || last_try_s) begin
                        y_nxt_s      = clamp9(rng.rand_in, Y_MIN_C, Y_MAX_C);
                        retry_nxt_s  = RETRY_W'(0);
                        spawn_nxt_s  = spawn_r + 8'd1;
                        next_state_s = ACTIVE;
                    end else begin
                        retry_nxt_s  = retry_r + RETRY_W'(1);
                    end
                end else begin
                    retry_nxt_s = retry_r;
                end
            end
            ACTIVE: begin
                if (hit) begin
                    cnt_nxt_s    = CNT_LOAD;
                    next_state_s = COOLDOWN;
                end else begin
                    next_state_s = ACTIVE;
                end
            end
            COOLDOWN: begin
                if (cnt_r == CNT_W'(0)) begin
                    next_state_s = DRAW_X;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset clears everything at once
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            retry_r    <= RETRY_W'(0);
            cnt_r      <= CNT_W'(0);
            x_r        <= X_MIN_C;
            y_r        <= Y_MIN_C;
            spawn_r    <= 8'd0;
            rand_req_r <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            retry_r    <= retry_nxt_s;
            cnt_r      <= cnt_nxt_s;
            x_r        <= x_nxt_s;
            y_r        <= y_nxt_s;
            spawn_r    <= spawn_nxt_s;
            rand_req_r <= (next_state_s == DRAW_X) || (next_state_s == DRAW_Y);
            active_r   <= (next_state_s == ACTIVE);
        end
    end

    assign rng.rand_req  = rand_req_r;
    assign target_x      = x_r;
    assign target_y      = y_r;
    assign target_active = active_r;
    assign spawn_count   = spawn_r;

endmodule
